// File: rtl/regfile_pkg.sv
// Shared types and constants for the parametrised register file.
package regfile_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } rf_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam int MIPS_ZERO = 0;
  localparam int MIPS_RA   = 31;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: busy blanking, hardwired zero, write bypass, array data.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              i_busy,
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_rdata
);

  always_comb begin
    o_rdata = i_mem_rdata;
    if (i_busy) begin
      o_rdata = '0;
    end else if ((ZERO_REG != 0) && (i_raddr == ADDR_W'(MIPS_ZERO))) begin
      o_rdata = '0;
    end else if ((BYPASS != 0) && i_we && (i_raddr == i_waddr)) begin
      o_rdata = i_wdata;
    end
  end

endmodule

// File: rtl/regfile_param.sv
// Parametrised GPR file with clear sweep after reset or on request.
// state    | meaning
// ST_IDLE  | normal read/write
// ST_CLEAR | zeroing mem[cnt_q] each edge, writes rejected
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NREAD*ADDR_W-1:0] i_raddr,
  output logic [NREAD*DATA_W-1:0] o_rdata,
  input  logic [ADDR_W-1:0]       i_waddr,
  input  logic [DATA_W-1:0]       i_wdata,
  input  logic                    i_we,
  input  logic                    i_clr,
  output logic                    o_busy,
  output logic                    o_wr_err
);

  localparam int DEPTH = 1 << ADDR_W;

  rf_state_e         state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              wr_err_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_waddr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              busy;

  // Reset counts as busy so reads are blanked before the first edge too.
  assign busy     = i_rst || (state_q == ST_CLEAR);
  assign o_busy   = busy;
  assign o_wr_err = wr_err_q;

  always_comb begin
    mem_we_d    = 1'b0;
    mem_waddr_d = i_waddr;
    mem_wdata_d = i_wdata;
    if (i_rst) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = '0;
      mem_wdata_d = '0;
    end else if (state_q == ST_CLEAR) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = cnt_q;
      mem_wdata_d = '0;
    end else if (i_we && !i_clr &&
                 !((ZERO_REG != 0) && (i_waddr == ADDR_W'(MIPS_ZERO)))) begin
      mem_we_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we_d) begin
      mem_q[mem_waddr_d] <= mem_wdata_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_CLEAR;
      cnt_q    <= '0;
      wr_err_q <= i_we;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A clear request wins over a same-edge write.
          wr_err_q <= i_we && i_clr;
          if (i_clr) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
          end
        end
        ST_CLEAR: begin
          wr_err_q <= i_we;
          cnt_q    <= cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q  <= ST_CLEAR;
          cnt_q    <= '0;
          wr_err_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] mem_rdata;

    assign raddr     = i_raddr[k*ADDR_W +: ADDR_W];
    assign mem_rdata = mem_q[raddr];

    regfile_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rdport (
      .i_busy      (busy),
      .i_raddr     (raddr),
      .i_we        (i_we),
      .i_waddr     (i_waddr),
      .i_wdata     (i_wdata),
      .i_mem_rdata (mem_rdata),
      .o_rdata     (o_rdata[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: two instances (zero+bypass, neither) share stimulus.
module tb_regfile_param;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NR*AW-1:0] raddr = '0;
  logic [NR*DW-1:0] rdata_a, rdata_b;
  logic [AW-1:0]  waddr = '0;
  logic [DW-1:0]  wdata = '0;
  logic           we = 1'b0;
  logic           clr = 1'b0;
  logic           busy_a, busy_b, err_a, err_b;

  always #5 clk = ~clk;

  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(1), .BYPASS(1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_raddr(raddr), .o_rdata(rdata_a),
    .i_waddr(waddr), .i_wdata(wdata), .i_we(we), .i_clr(clr),
    .o_busy(busy_a), .o_wr_err(err_a)
  );

  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(0), .BYPASS(0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_raddr(raddr), .o_rdata(rdata_b),
    .i_waddr(waddr), .i_wdata(wdata), .i_we(we), .i_clr(clr),
    .o_busy(busy_b), .o_wr_err(err_b)
  );

  typedef struct {
    string         tag;
    logic [DW-1:0] val;
  } exp_t;

  exp_t          exp_q[$];
  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] model_a [DEPTH];
  logic [DW-1:0] model_b [DEPTH];

  task automatic push(input string tag, input logic [DW-1:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [DW-1:0] obs);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL sb_empty observed=%h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      raddr = {AW'(i), AW'(i)};
      push({tag, "_a0"}, model_a[i]);
      push({tag, "_a1"}, model_a[i]);
      push({tag, "_b0"}, model_b[i]);
      push({tag, "_b1"}, model_b[i]);
      @(negedge clk);
      pop_chk(rdata_a[DW-1:0]);
      pop_chk(rdata_a[2*DW-1:DW]);
      pop_chk(rdata_b[DW-1:0]);
      pop_chk(rdata_b[2*DW-1:DW]);
      cyc();
    end
  endtask

  task automatic count_busy(input string tag);
    int na, nb;
    na = 0;
    nb = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy_a && !busy_b) break;
      na += int'(busy_a);
      nb += int'(busy_b);
      cyc();
    end
    push({tag, "_len_a"}, DW'(DEPTH));
    pop_chk(DW'(na));
    push({tag, "_len_b"}, DW'(DEPTH));
    pop_chk(DW'(nb));
    cyc();
  endtask

  task automatic fill_random();
    for (int i = 1; i < DEPTH; i++) begin
      we    = 1'b1;
      waddr = AW'(i);
      wdata = DW'($urandom_range(32767, 0));
      model_a[i] = wdata;
      model_b[i] = wdata;
      cyc();
    end
    we = 1'b0;
  endtask

  task automatic zero_models();
    for (int i = 0; i < DEPTH; i++) begin
      model_a[i] = '0;
      model_b[i] = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    zero_models();

    // Reset state
    raddr = {AW'(4), AW'(3)};
    cyc();
    push("rst_busy_a", 1);  push("rst_busy_b", 1);
    push("rst_err_a", 0);   push("rst_rd_a0", 0); push("rst_rd_b1", 0);
    @(negedge clk);
    pop_chk(DW'(busy_a)); pop_chk(DW'(busy_b));
    pop_chk(DW'(err_a));  pop_chk(rdata_a[DW-1:0]); pop_chk(rdata_b[2*DW-1:DW]);
    cyc();
    cyc();
    rst = 1'b0;
    count_busy("rst_busy");
    read_all("post_rst");

    fill_random();
    read_all("fill");

    // Write to entry 0: hardwired zero on A, normal storage on B
    we = 1'b1; waddr = '0; wdata = 32'hDEAD_BEEF; raddr = '0;
    push("z0_a0", 0); push("z0_a1", 0); push("z0_b0_old", model_b[0]);
    @(negedge clk);
    pop_chk(rdata_a[DW-1:0]); pop_chk(rdata_a[2*DW-1:DW]); pop_chk(rdata_b[DW-1:0]);
    cyc();
    we = 1'b0;
    model_b[0] = 32'hDEAD_BEEF;
    push("z1_a0", 0); push("z1_a1", 0); push("z1_b0", model_b[0]); push("z1_b1", model_b[0]);
    @(negedge clk);
    pop_chk(rdata_a[DW-1:0]); pop_chk(rdata_a[2*DW-1:DW]);
    pop_chk(rdata_b[DW-1:0]); pop_chk(rdata_b[2*DW-1:DW]);
    cyc();

    // Same-cycle bypass on A, old value then new on B
    we = 1'b1; waddr = AW'(7); wdata = 32'h0000_1234; raddr = {AW'(0), AW'(7)};
    push("byp_a0", 32'h1234); push("nobyp_b0_old", model_b[7]);
    @(negedge clk);
    pop_chk(rdata_a[DW-1:0]); pop_chk(rdata_b[DW-1:0]);
    cyc();
    we = 1'b0;
    model_a[7] = 32'h1234;
    model_b[7] = 32'h1234;
    push("byp_next_a0", 32'h1234); push("nobyp_next_b0", 32'h1234);
    @(negedge clk);
    pop_chk(rdata_a[DW-1:0]); pop_chk(rdata_b[DW-1:0]);
    cyc();

    // Clear request, rejected write to entry 5, ignored re-request mid-sweep
    clr = 1'b1;
    cyc();
    idx = 0;
    begin
      int na;
      na = 0;
      for (int k = 0; k < 100; k++) begin
        clr   = (idx == 5);
        we    = (idx == 0);
        waddr = AW'(5);
        wdata = 32'h0000_00AA;
        push("clr_err_a", DW'(idx == 1));
        push("clr_err_b", DW'(idx == 1));
        @(negedge clk);
        pop_chk(DW'(err_a));
        pop_chk(DW'(err_b));
        if (!busy_a) break;
        na++;
        cyc();
        idx++;
      end
      clr = 1'b0;
      we  = 1'b0;
      push("clr_busy_len", DW'(DEPTH));
      pop_chk(DW'(na));
    end
    cyc();
    zero_models();
    read_all("post_clr");

    // Reset at sweep cycle 10 restarts the sweep
    fill_random();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    for (int k = 0; k < 10; k++) cyc();
    rst = 1'b1;
    push("mid_rst_busy", 1); push("mid_rst_err", 0);
    @(negedge clk);
    pop_chk(DW'(busy_a)); pop_chk(DW'(err_a));
    cyc();
    cyc();
    rst = 1'b0;
    count_busy("mid_rst_busy");
    zero_models();
    read_all("post_mid_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised general-purpose register file for the MIPS32 datapath. It is the successor to the fixed 32x32, two-read/one-write register file. It adds configurable width, depth and read-port count, an optional hardwired zero register, optional write-to-read bypass, and a sequenced clear engine. The clear engine zeroes every entry after reset or on request. The block sits between decode (read addresses) and writeback (write port).

## Interface
Parameters:
- DATA_W, 32, data word width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NREAD, 2, number of independent read ports (1..4)
- ZERO_REG, 1, when 1, entry 0 always reads 0 and ignores writes
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching read ports

Ports:
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst  in  1  reset; synchronous, active-high
- i_raddr  in  NREAD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- o_rdata  out  NREAD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
- i_waddr  in  ADDR_W  write address
- i_wdata  in  DATA_W  write data
- i_we  in  1  write enable
- i_clr  in  1  one-cycle request to zero all entries
- o_busy  out  1  clear sweep in progress; writes are rejected
- o_wr_err  out  1  registered one-cycle pulse: a write was rejected because the block was busy

## Operation
- Storage: DEPTH x DATA_W array, written only on i_clk edges.
- FSM, 2 states:
  - IDLE: normal read/write.
  - CLEAR: sweep counter cnt (ADDR_W bits) writes 0 to mem[cnt] on each edge, then increments.
- Transitions:
  - Any state, i_rst=1 -> CLEAR, cnt=0.
  - IDLE with i_clr=1 -> CLEAR, cnt=0.
  - CLEAR with cnt=DEPTH-1 -> IDLE after that entry is written.
  - i_clr during CLEAR is ignored; the sweep is not restarted.
- While i_rst=1, mem[0] is written 0 each edge and cnt holds at 0.
- Writes in IDLE: when i_we=1 and not (ZERO_REG and i_waddr==0), mem[i_waddr] <= i_wdata.
- Writes during CLEAR (or with i_rst=1) are dropped. If i_we=1 at such an edge, o_wr_err=1 on the next cycle; otherwise o_wr_err=0.
- Reads are combinational from i_raddr. Per port, in priority order:
  1. o_busy=1 -> 0.
  2. ZERO_REG and addr==0 -> 0.
  3. BYPASS and i_we and addr==i_waddr -> i_wdata.
  4. Otherwise mem[addr].
- Multiple read ports with the same address return identical data.
- i_clr and i_we at the same edge in IDLE: the write is dropped, o_wr_err pulses and the sweep starts.

## Timing
- Reset values: o_busy=1 and o_wr_err=0 while i_rst=1; all o_rdata read 0.
- Clear length: o_busy stays 1 for exactly DEPTH cycles after the first edge with i_rst=0 (or after the edge accepting i_clr). It falls after the edge that clears entry DEPTH-1.
- Reset asserted mid-sweep restarts the sweep from entry 0. The full DEPTH cycles are needed again after release.
- Write latency:
  - Without bypass, data is visible on reads in the cycle after the write edge.
  - With BYPASS=1, data is visible in the same cycle as i_we.
- o_wr_err is registered: 1 cycle after the offending edge, asserted for 1 cycle.
- cnt wraps at DEPTH-1 only via the FSM exit; it never free-runs in IDLE.

## Structure
- Shared package regfile_pkg:
  - state encoding typedef (IDLE, CLEAR)
  - default DATA_W/ADDR_W constants
  - MIPS register-number constants (ZERO=0, RA=31)
- One natural sub-module: regfile_rdport. This is the per-port combinational mux (busy / zero / bypass / array) and is instantiated NREAD times via generate.
- Clear FSM, counter and array stay in the top module.

## Test plan
- Reset release with defaults: o_busy=1 for exactly 32 cycles, then 0. Every register read on both ports is 0.
- Write entries 1..31 with random values (mod 32768), one per cycle. Then read each on port 0 and port 1 with the same addresses: values match and entry 0 reads 0.
- Write 0xDEADBEEF to entry 0 with ZERO_REG=1: both ports read 0. With ZERO_REG=0 the next-cycle read is 0xDEADBEEF.
- BYPASS=1, i_we=1, i_waddr=7, i_wdata=0x1234, raddr0=7 in the same cycle: o_rdata0=0x1234 immediately. With BYPASS=0 it shows the old value, then 0x1234 on the next cycle.
- Pulse i_clr, then attempt a write to entry 5 during the sweep:
  - o_wr_err pulses for one cycle.
  - o_busy lasts 32 cycles.
  - Entry 5 reads 0 afterwards.
- Assert i_rst at sweep cycle 10 for 2 cycles: after release o_busy holds for a full 32 cycles and all entries read 0.
